pwm_ramp_ctrl: RTL and testbench
================================

PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 The block SHALL have one parameter: TICK_W, default 16, width of the step-interval register and counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (asserted at 0).
REQ-004 we_i  input  1  slave register write strobe, one write per asserted cycle.
REQ-005 addr_i  input  32  slave register address; only addr_i[7:0] decoded.
REQ-006 data_i  input  32  slave write data.
REQ-007 data_o  output  32  slave read data, combinational from addr_i.
REQ-008 pwm_we_o  output  1  write strobe to the PWM register port.
REQ-009 pwm_addr_o  output  32  PWM register address.
REQ-010 pwm_data_o  output  32  PWM register write data.
REQ-011 irq_o  output  1  one-cycle ramp-complete pulse (see Configuration).

Function
REQ-012 The block SHALL decode these registers at offset addr_i[7:0]: 0x00 CTRL (bit0 GO, self-clearing; bit1 ABORT, self-clearing; bits[7:4] ENMASK); 0x04 TICK; 0x08 STEP; 0x10+4n TARGET_n; 0x20+4n PERIOD_n (n=0..3); 0x30 STATUS (read-only: bit0 BUSY, bits[7:4] DONE sticky; any write to 0x30 clears DONE). Unmapped reads SHALL return 0.
REQ-013 The block SHALL keep a 32-bit current duty CUR_n per channel, readable at 0x40+4n.
REQ-014 The FSM SHALL have states IDLE, CFG, WAIT, UPD, FIN; BUSY=1 in every state except IDLE.
REQ-015 In IDLE, a write of GO=1 SHALL move to CFG on the next cycle; GO writes outside IDLE SHALL be ignored.
REQ-016 CFG SHALL last 5 cycles, issuing one PWM write per cycle in this order: PERIOD_0..3 to 0x00000000, 0x00010000, 0x00020000, 0x00030000; then {28'b0, ENMASK} to 0x00040000; it then enters WAIT.
REQ-017 WAIT SHALL count max(TICK,1) cycles with a TICK_W-bit counter, then enter UPD.
REQ-018 UPD SHALL last 4 cycles; in cycle n it SHALL update CUR_n and write the new value to 0x00100000 + (n<<16).
REQ-019 Update rule: if CUR_n < TARGET_n, CUR_n = min(CUR_n+S, TARGET_n); if greater, CUR_n = max(CUR_n-S, TARGET_n); if equal, unchanged. S = max(STEP,1). Arithmetic SHALL be 33-bit internally with no wrap-around in either direction.
REQ-020 After UPD cycle 3: if CUR_n == TARGET_n for all n, enter FIN; otherwise return to WAIT.
REQ-021 FIN SHALL last 1 cycle, set DONE[3:0]=4'b1111, pulse irq_o, and return to IDLE.
REQ-022 pwm_we_o SHALL be 1 only in CFG and UPD cycles; pwm_addr_o and pwm_data_o SHALL be 0 whenever pwm_we_o=0.
REQ-023 TARGET, STEP and TICK writes during a ramp SHALL take effect at the next WAIT or UPD evaluation. PERIOD writes during a ramp SHALL take effect only at the next GO.
REQ-024 An ABORT write in any non-IDLE state SHALL return the FSM to IDLE on the next cycle without a further PWM write, leaving CUR_n and DONE unchanged.
REQ-025 If ABORT and GO are written in the same cycle, ABORT SHALL win.

Reset
REQ-026 When rst=0, asynchronously: FSM=IDLE; all registers, CUR_n, DONE and the tick counter =0; pwm_we_o, pwm_addr_o, pwm_data_o and irq_o =0.
REQ-027 Reset asserted mid-ramp SHALL abort immediately with no partial PWM write after release.

Configuration
REQ-028 Macro PWM_RAMP_IRQ_EN: if defined, irq_o pulses per REQ-021. If undefined, irq_o SHALL be constant 0 and the DONE bits SHALL still be set.

Verification
REQ-029 PERIOD_0=99, ENMASK=4'b0001, TICK=2, STEP=10, TARGET_0=35, GO -> 5 CFG writes (99 to 0x0, 0x1 to 0x40000); B0 writes of 10, 20, 30, 35 at 2-cycle WAIT spacing; FIN; DONE=4'b1111; one irq_o pulse.
REQ-030 With CUR_0=35, TARGET_0=0 and STEP=0 -> 35 decrements of 1 each, final value 0, no underflow.
REQ-031 With CUR_1=0xFFFFFFF0, TARGET_1=0xFFFFFFFF and STEP=0x100 -> one write of 0xFFFFFFFF, no wrap-around.
REQ-032 ABORT written during WAIT -> IDLE on the next cycle; pwm_we_o stays 0 and CUR_n holds.
REQ-033 rst pulled low during UPD cycle 2 -> all outputs 0 in the same cycle and state reads 0 after release.
REQ-034 With the macro undefined, the REQ-029 stimulus -> irq_o stays 0 and STATUS reads 0xF0.

Source files
------------

// File: rtl/pwm_ramp_ctrl.sv
// PWM duty ramp controller: programs four PWM channels, then steps each CUR_n toward TARGET_n.
// Optional define PWM_RAMP_IRQ_EN drives irq_o on ramp completion; otherwise irq_o is tied low.
module pwm_ramp_ctrl #(
    parameter int unsigned TICK_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        pwm_we_o,
    output logic [31:0] pwm_addr_o,
    output logic [31:0] pwm_data_o,
    output logic        irq_o
);
    localparam int unsigned DW  = 32;
    localparam int unsigned NCH = 4;

    typedef enum logic [2:0] {S_IDLE, S_CFG, S_WAIT, S_UPD, S_FIN} state_e;

    state_e                   state_q, state_d;
    logic [2:0]               idx_q, idx_d;
    logic [TICK_W-1:0]        wcnt_q, wcnt_d;
    logic [TICK_W-1:0]        tick_q;
    logic [DW-1:0]            step_q;
    logic [3:0]               enmask_q;
    logic [3:0]               done_q;
    logic [NCH-1:0][DW-1:0]   target_q, period_q, period_sh_q, cur_q;

    logic              wr_ctrl_c, go_c, abort_c, upd_en_c, fin_c, all_eq_c;
    logic [TICK_W-1:0] tick_eff_c;
    logic [DW-1:0]     cur_sel_c, tgt_sel_c, nxt_c;
    logic [DW:0]       step_eff_c, sum_c, dif_c;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^addr_i[31:8];

    assign wr_ctrl_c  = we_i && (addr_i[7:0] == 8'h00);
    assign go_c       = wr_ctrl_c && data_i[0] && !data_i[1];
    assign abort_c    = wr_ctrl_c && data_i[1];
    assign tick_eff_c = (tick_q == '0) ? TICK_W'(1) : tick_q;

    // Next duty for the channel selected by idx_q; 33-bit so neither direction wraps.
    always_comb begin
        cur_sel_c  = cur_q[idx_q[1:0]];
        tgt_sel_c  = target_q[idx_q[1:0]];
        step_eff_c = (step_q == '0) ? 33'd1 : {1'b0, step_q};
        sum_c      = {1'b0, cur_sel_c} + step_eff_c;
        dif_c      = {1'b0, cur_sel_c} - step_eff_c;
        nxt_c      = cur_sel_c;
        if (cur_sel_c < tgt_sel_c) begin
            nxt_c = (sum_c > {1'b0, tgt_sel_c}) ? tgt_sel_c : sum_c[DW-1:0];
        end else if (cur_sel_c > tgt_sel_c) begin
            nxt_c = (dif_c[DW] || (dif_c[DW-1:0] < tgt_sel_c)) ? tgt_sel_c : dif_c[DW-1:0];
        end
    end

    // Channels 0..2 were already committed earlier in the UPD pass.
    assign all_eq_c = (cur_q[0] == target_q[0]) && (cur_q[1] == target_q[1]) &&
                      (cur_q[2] == target_q[2]) && (nxt_c == target_q[3]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wcnt_d     = wcnt_q;
        pwm_we_o   = 1'b0;
        pwm_addr_o = '0;
        pwm_data_o = '0;
        upd_en_c   = 1'b0;
        fin_c      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go_c) begin
                    state_d = S_CFG;
                    idx_d   = '0;
                end
            end
            S_CFG: begin
                pwm_we_o = 1'b1;
                if (idx_q == 3'd4) begin
                    pwm_addr_o = 32'h0004_0000;
                    pwm_data_o = {28'b0, enmask_q};
                    state_d    = S_WAIT;
                    wcnt_d     = '0;
                end else begin
                    pwm_addr_o = {14'b0, idx_q[1:0], 16'b0};
                    pwm_data_o = period_sh_q[idx_q[1:0]];
                    idx_d      = idx_q + 3'd1;
                end
            end
            S_WAIT: begin
                if (wcnt_q >= tick_eff_c - TICK_W'(1)) begin
                    state_d = S_UPD;
                    idx_d   = '0;
                    wcnt_d  = '0;
                end else begin
                    wcnt_d = wcnt_q + TICK_W'(1);
                end
            end
            S_UPD: begin
                pwm_we_o   = 1'b1;
                upd_en_c   = 1'b1;
                pwm_addr_o = {11'b0, 1'b1, 2'b0, idx_q[1:0], 16'b0};
                pwm_data_o = nxt_c;
                if (idx_q == 3'd3) begin
                    state_d = all_eq_c ? S_FIN : S_WAIT;
                    wcnt_d  = '0;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            S_FIN: begin
                fin_c   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Abort cancels the current cycle's PWM write and CUR/DONE update.
        if (abort_c && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            pwm_we_o   = 1'b0;
            pwm_addr_o = '0;
            pwm_data_o = '0;
            upd_en_c   = 1'b0;
            fin_c      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_q      <= '0;
            step_q      <= '0;
            enmask_q    <= '0;
            done_q      <= '0;
            target_q    <= '0;
            period_q    <= '0;
            period_sh_q <= '0;
            cur_q       <= '0;
        end else begin
            if (we_i) begin
                if (addr_i[7:0] == 8'h00) enmask_q <= data_i[7:4];
                if (addr_i[7:0] == 8'h04) tick_q   <= data_i[TICK_W-1:0];
                if (addr_i[7:0] == 8'h08) step_q   <= data_i;
                if (addr_i[7:0] == 8'h30) done_q   <= '0;
                for (int n = 0; n < NCH; n++) begin
                    if (addr_i[7:0] == 8'(16 + 4 * n)) target_q[n] <= data_i;
                    if (addr_i[7:0] == 8'(32 + 4 * n)) period_q[n] <= data_i;
                end
            end
            if ((state_q == S_IDLE) && go_c) period_sh_q <= period_q;
            if (upd_en_c) cur_q[idx_q[1:0]] <= nxt_c;
            if (fin_c) done_q <= 4'b1111;
        end
    end

    always_comb begin
        data_o = '0;
        case (addr_i[7:0])
            8'h00:   data_o = {24'b0, enmask_q, 4'b0};
            8'h04:   data_o = DW'(tick_q);
            8'h08:   data_o = step_q;
            8'h30:   data_o = {24'b0, done_q, 3'b0, (state_q != S_IDLE)};
            default: data_o = '0;
        endcase
        for (int n = 0; n < NCH; n++) begin
            if (addr_i[7:0] == 8'(16 + 4 * n)) data_o = target_q[n];
            if (addr_i[7:0] == 8'(32 + 4 * n)) data_o = period_q[n];
            if (addr_i[7:0] == 8'(64 + 4 * n)) data_o = cur_q[n];
        end
    end

`ifdef PWM_RAMP_IRQ_EN
    assign irq_o = fin_c;
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: logs every PWM write and checks against hand-computed vectors.
module tb_pwm_ramp_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [31:0] addr_i, data_i, data_o;
    logic        pwm_we_o, irq_o;
    logic [31:0] pwm_addr_o, pwm_data_o;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int irq_cnt = 0;
    int bus_viol = 0;
    logic [31:0] log_a[$];
    logic [31:0] log_d[$];
    int          log_c[$];
    logic [31:0] sel_d[$];
    int          sel_c[$];

    pwm_ramp_ctrl #(.TICK_W(16)) dut (
        .clk(clk), .rst(rst), .we_i(we_i), .addr_i(addr_i), .data_i(data_i),
        .data_o(data_o), .pwm_we_o(pwm_we_o), .pwm_addr_o(pwm_addr_o),
        .pwm_data_o(pwm_data_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            if (pwm_we_o) begin
                log_a.push_back(pwm_addr_o);
                log_d.push_back(pwm_data_o);
                log_c.push_back(cyc);
            end else if (pwm_addr_o != 0 || pwm_data_o != 0) begin
                bus_viol++;
            end
            if (irq_o) irq_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        we_i = 1'b1; addr_i = {24'b0, a}; data_i = d;
        @(posedge clk); #1;
        we_i = 1'b0; addr_i = '0; data_i = '0;
    endtask

    task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
        addr_i = {24'b0, a};
        #1 d = data_o;
        addr_i = '0;
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        logic [31:0] s;
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            bus_rd(8'h30, s);
            n++;
        end while (s[0] && n < max_cyc);
        check(tag, 32'(s[0]), 32'd0);
    endtask

    task automatic clear_log();
        log_a.delete(); log_d.delete(); log_c.delete();
    endtask

    task automatic pick(input logic [31:0] a);
        sel_d.delete(); sel_c.delete();
        for (int i = 0; i < log_a.size(); i++) begin
            if (log_a[i] == a) begin
                sel_d.push_back(log_d[i]);
                sel_c.push_back(log_c[i]);
            end
        end
    endtask

    task automatic ramp_ch1(input string tag, input logic [31:0] tgt, input logic [31:0] stp,
                            input logic [31:0] exp);
        bus_wr(8'h30, 32'd0);
        bus_wr(8'h14, tgt);
        bus_wr(8'h08, stp);
        clear_log();
        bus_wr(8'h00, 32'h11);
        wait_idle(100, {tag, "_idle"});
        pick(32'h0011_0000);
        check({tag, "_n"}, 32'(sel_d.size()), 32'd1);
        if (sel_d.size() > 0) check({tag, "_val"}, sel_d[0], exp);
    endtask

    logic [31:0] rd;
    logic [31:0] cfg_a [5] = '{32'h0, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000};
    logic [31:0] cfg_d [5] = '{32'd99, 32'd0, 32'd0, 32'd0, 32'd1};
    logic [31:0] ramp0 [4] = '{32'd10, 32'd20, 32'd30, 32'd35};
    logic        found;

    initial begin
        rst = 1'b0; we_i = 1'b0; addr_i = '0; data_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pwm", {pwm_we_o, irq_o, 30'b0} | pwm_addr_o | pwm_data_o, 32'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        bus_rd(8'h30, rd); check("rst_status", rd, 32'h0);
        bus_rd(8'h40, rd); check("rst_cur0", rd, 32'h0);

        // Basic ramp of channel 0 up to 35 in steps of 10
        bus_wr(8'h20, 32'd99);
        bus_wr(8'h04, 32'd2);
        bus_wr(8'h08, 32'd10);
        bus_wr(8'h10, 32'd35);
        clear_log();
        irq_cnt = 0;
        bus_wr(8'h00, 32'h11);
        wait_idle(200, "t1_idle");
        check("t1_nwr", 32'(log_a.size()), 32'd21);
        for (int i = 0; i < 5 && i < log_a.size(); i++) begin
            check($sformatf("t1_cfg%0d_a", i), log_a[i], cfg_a[i]);
            check($sformatf("t1_cfg%0d_d", i), log_d[i], cfg_d[i]);
        end
        pick(32'h0010_0000);
        check("t1_n0", 32'(sel_d.size()), 32'd4);
        for (int i = 0; i < 4 && i < sel_d.size(); i++)
            check($sformatf("t1_b0_%0d", i), sel_d[i], ramp0[i]);
        if (sel_c.size() >= 2 && log_c.size() >= 5) begin
            check("t1_first_gap", 32'(sel_c[0] - log_c[4]), 32'd3);
            check("t1_spacing", 32'(sel_c[1] - sel_c[0]), 32'd6);
        end
        bus_rd(8'h30, rd); check("t1_status", rd, 32'hF0);
        bus_rd(8'h40, rd); check("t1_cur0", rd, 32'd35);
`ifdef PWM_RAMP_IRQ_EN
        check("t1_irq", 32'(irq_cnt), 32'd1);
`else
        check("t1_irq", 32'(irq_cnt), 32'd0);
`endif

        // Ramp down by the minimum step of 1, ending exactly at zero
        bus_wr(8'h30, 32'd0);
        bus_rd(8'h30, rd); check("t2_done_clr", rd, 32'h0);
        bus_wr(8'h10, 32'd0);
        bus_wr(8'h08, 32'd0);
        bus_wr(8'h04, 32'd0);
        clear_log();
        bus_wr(8'h00, 32'h11);
        wait_idle(400, "t2_idle");
        pick(32'h0010_0000);
        check("t2_n0", 32'(sel_d.size()), 32'd35);
        for (int i = 0; i < 35 && i < sel_d.size(); i++)
            check($sformatf("t2_b0_%0d", i), sel_d[i], 32'(34 - i));
        if (sel_c.size() >= 2) check("t2_spacing", 32'(sel_c[1] - sel_c[0]), 32'd5);
        bus_rd(8'h40, rd); check("t2_cur0", rd, 32'd0);

        // Saturation at both ends of the 32-bit range
        ramp_ch1("t3_big", 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'hFFFF_FFF0);
        ramp_ch1("t3_top", 32'hFFFF_FFFF, 32'h0000_0100, 32'hFFFF_FFFF);
        ramp_ch1("t3_down", 32'd5, 32'hFFFF_FFFF, 32'd5);
        bus_rd(8'h44, rd); check("t3_cur1", rd, 32'd5);

        // ABORT together with GO in IDLE: nothing starts
        clear_log();
        bus_wr(8'h00, 32'h13);
        repeat (3) @(posedge clk);
        #1;
        bus_rd(8'h30, rd); check("t4_go_abort_busy", 32'(rd[0]), 32'd0);
        check("t4_go_abort_nwr", 32'(log_a.size()), 32'd0);

        // ABORT during WAIT
        bus_wr(8'h10, 32'd100);
        bus_wr(8'h08, 32'd1);
        bus_wr(8'h04, 32'd50);
        bus_wr(8'h00, 32'h11);
        repeat (10) @(posedge clk);
        #1;
        bus_rd(8'h30, rd); check("t4_busy_wait", 32'(rd[0]), 32'd1);
        clear_log();
        bus_wr(8'h00, 32'h12);
        bus_rd(8'h30, rd); check("t4_abort_status", rd, 32'hF0);
        repeat (60) @(posedge clk);
        #1;
        check("t4_abort_nwr", 32'(log_a.size()), 32'd0);
        bus_rd(8'h40, rd); check("t4_cur0", rd, 32'd0);
        bus_rd(8'h44, rd); check("t4_cur1", rd, 32'd5);

        // Reset during UPD cycle 2
        bus_wr(8'h04, 32'd3);
        bus_wr(8'h00, 32'h11);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk); #1;
            if (pwm_we_o && pwm_addr_o == 32'h0012_0000) found = 1'b1;
        end
        check("t5_found_upd2", 32'(found), 32'd1);
        #2 rst = 1'b0;
        #1 check("t5_rst_outs", {pwm_we_o, irq_o, 30'b0} | pwm_addr_o | pwm_data_o, 32'd0);
        @(negedge clk) rst = 1'b1;
        clear_log();
        @(posedge clk); #1;
        bus_rd(8'h30, rd); check("t5_status", rd, 32'h0);
        bus_rd(8'h40, rd); check("t5_cur0", rd, 32'h0);
        bus_rd(8'h10, rd); check("t5_tgt0", rd, 32'h0);
        repeat (20) @(posedge clk);
        #1;
        check("t5_nwr", 32'(log_a.size()), 32'd0);
        check("idle_bus_zero", 32'(bus_viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
